// File: rtl/pong_pkg.sv
// Shared definitions for the Pong controller slice: screen and sprite
// geometry, derived pixel counts and the sequencer state encoding.
package pong_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int PAD_W    = 2;
  localparam int PAD_H    = 16;
  localparam int BALL_W   = 4;

  localparam int SCREEN_PIX_C = SCREEN_W * SCREEN_H;  // 19200
  localparam int PAD_PIX_C    = PAD_W * PAD_H;        // 32
  localparam int BALL_PIX_C   = BALL_W * BALL_W;      // 16

  localparam int PIX_CNT_W = 15;

  typedef enum logic [3:0] {
    S_MENU,
    S_SU_CLEAR,
    S_CLEAR,
    S_SU_LEFT,
    S_DRAW_LEFT,
    S_SU_RIGHT,
    S_DRAW_RIGHT,
    S_SU_BALL,
    S_DRAW_BALL,
    S_WAIT,
    S_MOVE_PADS,
    S_MOVE_BALL,
    S_GAMEOVER
  } state_e;

endpackage

// File: rtl/rate_divider.sv
// Free-running tick generator: counts 0..DIV-1 and wraps, raising tick
// for the single cycle at DIV-1.
//   clk    : system clock
//   resetn : synchronous active-low reset, counter back to 0
//   tick   : one-cycle pulse every DIV cycles
module rate_divider #(
  parameter int DIV = 833333
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pong_control.sv
// Per-frame sequencer for the Pong datapath: clear screen, draw both pads
// and the ball, wait for the frame tick, then move pads and ball. Also owns
// the menu / game-over handshake with the start key.
//   clk, resetn          : clock, synchronous active-low reset
//   start                : start/restart key level (already synchronised)
//   gameover             : datapath game-over flag
//   menu                 : hold datapath in its initial state
//   set_up_* / clear_screen / draw_* : datapath action strobes
//   reset_delta          : zero datapath deltas (every set-up state)
//   move_pads, move_ball : one-cycle move strobes
//   plot                 : VGA write enable, one cycle behind the draw strobes
module pong_control
  import pong_pkg::*;
#(
  parameter int FRAME_DIV  = 833333,
  parameter int SCREEN_PIX = SCREEN_PIX_C,
  parameter int PAD_PIX    = PAD_PIX_C,
  parameter int BALL_PIX   = BALL_PIX_C
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic gameover,
  output logic menu,
  output logic set_up_clear_screen,
  output logic clear_screen,
  output logic set_up_left_pad,
  output logic draw_left_pad,
  output logic set_up_right_pad,
  output logic draw_right_pad,
  output logic set_up_ball,
  output logic draw_ball,
  output logic reset_delta,
  output logic move_pads,
  output logic move_ball,
  output logic plot
);

  localparam logic [PIX_CNT_W-1:0] SCREEN_LAST = PIX_CNT_W'(SCREEN_PIX - 1);
  localparam logic [PIX_CNT_W-1:0] PAD_LAST    = PIX_CNT_W'(PAD_PIX - 1);
  localparam logic [PIX_CNT_W-1:0] BALL_LAST   = PIX_CNT_W'(BALL_PIX - 1);

  state_e               state_q, state_d;
  logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic                 start_q;
  logic                 plot_q, plot_d;
  logic                 start_rise;
  logic                 frame_tick;
  logic                 drawing;

  rate_divider #(.DIV(FRAME_DIV)) u_frame_div (
    .clk    (clk),
    .resetn (resetn),
    .tick   (frame_tick)
  );

  assign start_rise = start & ~start_q;
  assign plot       = plot_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_MENU;
      pix_cnt_q <= '0;
      start_q   <= 1'b0;
      plot_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      start_q   <= start;
      plot_q    <= plot_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    pix_cnt_d           = pix_cnt_q;
    menu                = 1'b0;
    set_up_clear_screen = 1'b0;
    clear_screen        = 1'b0;
    set_up_left_pad     = 1'b0;
    draw_left_pad       = 1'b0;
    set_up_right_pad    = 1'b0;
    draw_right_pad      = 1'b0;
    set_up_ball         = 1'b0;
    draw_ball           = 1'b0;
    reset_delta         = 1'b0;
    move_pads           = 1'b0;
    move_ball           = 1'b0;
    drawing             = 1'b0;

    unique case (state_q)
      S_MENU: begin
        menu = 1'b1;
        if (start_rise) state_d = S_SU_CLEAR;
      end
      S_SU_CLEAR: begin
        set_up_clear_screen = 1'b1;
        reset_delta         = 1'b1;
        pix_cnt_d           = '0;
        state_d             = S_CLEAR;
      end
      S_CLEAR: begin
        clear_screen = 1'b1;
        drawing      = 1'b1;
        pix_cnt_d    = pix_cnt_q + 1'b1;
        if (pix_cnt_q == SCREEN_LAST) state_d = S_SU_LEFT;
      end
      S_SU_LEFT: begin
        set_up_left_pad = 1'b1;
        reset_delta     = 1'b1;
        pix_cnt_d       = '0;
        state_d         = S_DRAW_LEFT;
      end
      S_DRAW_LEFT: begin
        draw_left_pad = 1'b1;
        drawing       = 1'b1;
        pix_cnt_d     = pix_cnt_q + 1'b1;
        if (pix_cnt_q == PAD_LAST) state_d = S_SU_RIGHT;
      end
      S_SU_RIGHT: begin
        set_up_right_pad = 1'b1;
        reset_delta      = 1'b1;
        pix_cnt_d        = '0;
        state_d          = S_DRAW_RIGHT;
      end
      S_DRAW_RIGHT: begin
        draw_right_pad = 1'b1;
        drawing        = 1'b1;
        pix_cnt_d      = pix_cnt_q + 1'b1;
        if (pix_cnt_q == PAD_LAST) state_d = S_SU_BALL;
      end
      S_SU_BALL: begin
        set_up_ball = 1'b1;
        reset_delta = 1'b1;
        pix_cnt_d   = '0;
        state_d     = S_DRAW_BALL;
      end
      S_DRAW_BALL: begin
        draw_ball = 1'b1;
        drawing   = 1'b1;
        pix_cnt_d = pix_cnt_q + 1'b1;
        if (pix_cnt_q == BALL_LAST) state_d = S_WAIT;
      end
      // The tick is free-running; one missed while drawing is simply lost.
      S_WAIT: if (frame_tick) state_d = S_MOVE_PADS;
      S_MOVE_PADS: begin
        move_pads = 1'b1;
        state_d   = S_MOVE_BALL;
      end
      // The flag reflects the previous frame's score update; the one-frame
      // lag is accepted.
      S_MOVE_BALL: begin
        move_ball = 1'b1;
        state_d   = gameover ? S_GAMEOVER : S_SU_CLEAR;
      end
      // Returning to MENU needs its own press, so a held key cannot restart.
      S_GAMEOVER: begin
        menu = 1'b1;
        if (start_rise) state_d = S_MENU;
      end
      default: state_d = S_MENU;
    endcase

    // Registered to line up with the datapath's registered x/y.
    plot_d = drawing;
  end

endmodule

// File: tb/tb_pong_control.sv
module tb_pong_control;
  import pong_pkg::*;

  localparam int FDIV = 64;

  logic clk = 1'b0;
  logic resetn, start, gameover;
  logic menu, set_up_clear_screen, clear_screen, set_up_left_pad, draw_left_pad;
  logic set_up_right_pad, draw_right_pad, set_up_ball, draw_ball;
  logic reset_delta, move_pads, move_ball, plot;
  logic [9:0] stb;

  int total = 0, bad = 0;
  int cyc = 0, plot_err = 0, hot_err = 0, rd_err = 0, prun = 0;
  int plot_runs[$];
  logic exp_plot = 1'b0;
  logic mon_en = 1'b0;
  int mp1, mp2;

  always #5 clk = ~clk;

  pong_control #(.FRAME_DIV(FDIV)) dut (
    .clk(clk), .resetn(resetn), .start(start), .gameover(gameover),
    .menu(menu), .set_up_clear_screen(set_up_clear_screen), .clear_screen(clear_screen),
    .set_up_left_pad(set_up_left_pad), .draw_left_pad(draw_left_pad),
    .set_up_right_pad(set_up_right_pad), .draw_right_pad(draw_right_pad),
    .set_up_ball(set_up_ball), .draw_ball(draw_ball), .reset_delta(reset_delta),
    .move_pads(move_pads), .move_ball(move_ball), .plot(plot)
  );

  // bit 0 = set_up_clear_screen ... bit 9 = move_ball
  assign stb = {move_ball, move_pads, draw_ball, set_up_ball, draw_right_pad,
                set_up_right_pad, draw_left_pad, set_up_left_pad, clear_screen,
                set_up_clear_screen};

  // Pre-edge observer: plot alignment, strobe exclusivity, reset_delta, plot runs.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mon_en) begin
      if (plot !== exp_plot) plot_err <= plot_err + 1;
      if ($countones(stb) > 1) hot_err <= hot_err + 1;
      if (reset_delta !== (stb[0] | stb[2] | stb[4] | stb[6])) rd_err <= rd_err + 1;
    end
    exp_plot <= resetn & (stb[1] | stb[3] | stb[5] | stb[7]);
    if (plot === 1'b1) prun <= prun + 1;
    else if (prun > 0) begin
      plot_runs.push_back(prun);
      prun <= 0;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run_len(input string tag, input int idx, input int len);
    int n = 0;
    while (stb[idx] === 1'b1 && n < len + 4) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, len);
  endtask

  task automatic wait_for(input string tag, input int idx, input int bound);
    int n = 0;
    while (stb[idx] !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(stb[idx]), 1);
  endtask

  // From the first SU_CLEAR cycle through the last ball pixel.
  task automatic draw_frame(input string pfx);
    chk({pfx, "_suclr"}, int'(set_up_clear_screen), 1);
    run_len({pfx, "_suclr_len"}, 0, 1);
    chk({pfx, "_plot_clr0"}, int'(plot), 0);
    run_len({pfx, "_clr_len"}, 1, SCREEN_PIX_C);
    run_len({pfx, "_sul_len"}, 2, 1);
    run_len({pfx, "_dl_len"}, 3, PAD_PIX_C);
    run_len({pfx, "_sur_len"}, 4, 1);
    run_len({pfx, "_dr_len"}, 5, PAD_PIX_C);
    run_len({pfx, "_sub_len"}, 6, 1);
    run_len({pfx, "_db_len"}, 7, BALL_PIX_C);
    chk({pfx, "_wait_stb"}, int'(stb), 0);
    chk({pfx, "_wait_menu"}, int'(menu), 0);
  endtask

  task automatic chk_plot_runs(input string pfx);
    chk({pfx, "_pruns_n"}, plot_runs.size(), 4);
    if (plot_runs.size() == 4) begin
      chk({pfx, "_prun_clr"}, plot_runs[0], SCREEN_PIX_C);
      chk({pfx, "_prun_l"}, plot_runs[1], PAD_PIX_C);
      chk({pfx, "_prun_r"}, plot_runs[2], PAD_PIX_C);
      chk({pfx, "_prun_b"}, plot_runs[3], BALL_PIX_C);
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; gameover = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    mon_en = 1'b1;

    // 1: reset and idle
    chk("rst_menu", int'(menu), 1);
    chk("rst_plot", int'(plot), 0);
    repeat (100) @(negedge clk);
    chk("idle_state", int'(dut.state_q), int'(S_MENU));
    chk("idle_menu", int'(menu), 1);
    chk("idle_plot", int'(plot), 0);
    chk("idle_stb", int'(stb), 0);
    chk("idle_rd", int'(reset_delta), 0);

    // 2: first frame
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    plot_runs.delete();
    draw_frame("f1");

    // 3: move pulses and frame spacing
    wait_for("f1_mp_to", 8, 100);
    mp1 = cyc;
    run_len("f1_mp_len", 8, 1);
    run_len("f1_mb_len", 9, 1);
    chk("f1_next_suclr", int'(set_up_clear_screen), 1);
    chk_plot_runs("f1");
    wait_for("f2_mp_to", 8, 20000);
    mp2 = cyc;
    // move_pads always follows a tick, so the spacing is a tick multiple.
    chk("mp_gap", mp2 - mp1, 19328);
    chk("mp_gap_min", int'((mp2 - mp1) >= SCREEN_PIX_C + 88), 1);

    // 4: game over, held key, two presses to restart
    gameover = 1'b1;
    start = 1'b1;
    run_len("f2_mp_len", 8, 1);
    chk("f2_mb", int'(move_ball), 1);
    @(negedge clk);
    gameover = 1'b0;
    chk("go_state", int'(dut.state_q), int'(S_GAMEOVER));
    chk("go_menu", int'(menu), 1);
    chk("go_stb", int'(stb), 0);
    repeat (10) @(negedge clk);
    chk("go_held", int'(dut.state_q), int'(S_GAMEOVER));
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("go_to_menu", int'(dut.state_q), int'(S_MENU));
    repeat (5) @(negedge clk);
    chk("menu_held", int'(dut.state_q), int'(S_MENU));
    chk("menu_held_stb", int'(stb), 0);
    chk("menu_held_menu", int'(menu), 1);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_suclr", int'(set_up_clear_screen), 1);

    // 5: reset mid-clear
    @(negedge clk);
    repeat (5000) @(negedge clk);
    chk("mid_clr", int'(clear_screen), 1);
    chk("mid_pix", int'(dut.pix_cnt_q), 5000);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("mr_state", int'(dut.state_q), int'(S_MENU));
    chk("mr_menu", int'(menu), 1);
    chk("mr_clr", int'(clear_screen), 0);
    chk("mr_plot", int'(plot), 0);
    repeat (3) @(negedge clk);
    plot_runs.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    draw_frame("f3");
    wait_for("f3_mp_to", 8, 100);
    run_len("f3_mp_len", 8, 1);
    run_len("f3_mb_len", 9, 1);
    chk("f3_next_suclr", int'(set_up_clear_screen), 1);
    chk_plot_runs("f3");

    // 6: whole-run observer results
    chk("plot_align_errs", plot_err, 0);
    chk("strobe_hot_errs", hot_err, 0);
    chk("reset_delta_errs", rd_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
